array_mult_sched: RTL and testbench
===================================

Name: array_mult_sched

Overview:
- Shares the single 15-lane, 36-bit array multiplier between NREQ requesters in the IK pipeline (for example, the Jacobian, transpose and update units).
- Sequences the array's own synchronous reset after system reset.
- Grants one requester per cycle using round-robin arbitration and drives that requester's operand vectors into the array.
- Tracks every in-flight operation through the array's fixed pipeline latency and returns each result to the requester that issued it.

Parameters:
- N, 15, number of multiplier lanes.
- W, 36, bits per lane operand and per lane result.
- NREQ, 3, number of requesters (2..8).
- MULT_LAT, 4, array latency in cycles counted while mult_en is high (1..16).
- RST_CYC, 4, number of cycles mult_rst is held after system reset (>=1).
- TAG_W, $clog2(NREQ), width of the requester-index tag.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset; asynchronous, active-low.
- req_valid, in, NREQ, requester i has an operation pending.
- req_ready, out, NREQ, requester i is granted this cycle (one-hot or zero).
- req_a, in, NREQ x N x W, operand A vectors.
- req_b, in, NREQ x N x W, operand B vectors.
- resp_valid, out, NREQ, result for requester i is present on resp_result (one-hot or zero).
- resp_result, out, N x W, result vector, broadcast to all requesters.
- mult_en, out, 1, array enable.
- mult_rst, out, 1, array synchronous reset, active-high.
- mult_a, out, N x W, array dataa.
- mult_b, out, N x W, array datab.
- mult_result, in, N x W, array result.
- busy, out, 1, at least one operation is in flight.

Behaviour:
- Reset values while rst is low: state=INIT, counter=0, RR pointer=0, tracker cleared, req_ready=0, resp_valid=0, mult_en=0, mult_rst=1, mult_a=0, mult_b=0, busy=0.
- States:
  - INIT: mult_rst=1, counter increments each cycle. Transition to RUN when counter==RST_CYC-1. No grants are given in INIT.
  - RUN: arbitration and issue as described below. RUN is left only by reset.
- Arbitration in RUN:
  - Scan starts at the RR pointer; the first requester with req_valid set is granted.
  - req_ready is combinational from req_valid and the pointer.
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - After a grant to i, the pointer becomes (i+1) mod NREQ; with no grant the pointer holds.
  - A requester must hold its request stable until it is granted.
- Issue:
  - mult_a and mult_b are combinational muxes of the granted requester's operands; they are 0 when nothing is granted.
  - issue = any transfer. One issue per cycle at most, so throughput is 1 op/cycle.
- Tracker:
  - MULT_LAT-stage shift register of {valid, tag}.
  - Stage 0 is loaded with {issue, granted index}.
  - Shifts only when mult_en is high.
- mult_en = issue OR any tracker stage valid.
  - When the array is idle, mult_en is low and the pipeline freezes.
  - Because the tracker freezes too, the alignment between tags and array data is preserved.
- Response:
  - When the last tracker stage is valid and mult_en is high, resp_valid[tag]=1 for one cycle, and resp_result carries mult_result.
  - resp_result is passed through combinationally. Requesters have no backpressure and must accept the response in that cycle.
- Latency: exactly MULT_LAT enabled cycles from issue to resp_valid. Back-to-back issues return back-to-back, in issue order.
- busy = OR of all tracker stage valid bits.
- Simultaneous events: an issue and a response in the same cycle are legal and proceed independently.
- Reset asserted mid-operation: in-flight operations are discarded, no response is produced for them, and INIT is re-run.
- Arithmetic: none inside this block. Lane data passes through unmodified at width W.

Decomposition:
- Package array_mult_pkg:
  - N, W and MULT_LAT defaults.
  - Typedef lane_vec_t = logic [N-1:0][W-1:0].
  - Typedef sched_state_e = {INIT, RUN}.
  - Typedef trk_entry_t = struct {valid, tag}.
- Sub-module rr_arbiter (NREQ): inputs req, pointer-advance enable and clk/rst; output one-hot grant. The arbiter holds the RR pointer.

Test Plan:
- Reset sequence: release rst -> mult_rst=1 for exactly 4 cycles, req_ready=0 throughout, then RUN. Requests raised during INIT are granted only once RUN is entered.
- Single op: requester 1 issues with all lanes A=3, B=5 -> 4 cycles after issue, resp_valid=3'b010 and every lane of resp_result=15; mult_en drops the following cycle; busy=0.
- Round-robin: all three req_valid held high for 6 cycles -> grant order 0,1,2,0,1,2; responses arrive back-to-back in the same order, with each lane matching A*B for that requester.
- Idle gap freeze: issue op X, drop all requests for 10 cycles with the pipeline draining, then issue op Y -> X responds after 4 enabled cycles, Y after 4 enabled cycles, tags are correct, and no spurious resp_valid occurs.
- Mid-flight reset: issue 3 ops, assert rst at cycle 2 -> all outputs return to reset values immediately and no resp_valid occurs for those ops. INIT repeats for 4 cycles; a new op then returns correctly.
- Corner operands: lane A=36'hFFFFFFFFF, B=1 and lane A=0 -> resp_result equals mult_result passed through bit-exact, with no lane crosstalk across all 15 lanes.

Source files
------------

// File: rtl/array_mult_pkg.sv
// -----------------------------------------------------------------------------
// array_mult_pkg
// Shared types and defaults for the array multiplier scheduler.
//   N, W          : lane count and lane width of the shared array multiplier
//   MULT_LAT_DEF  : default array latency in enabled cycles
//   lane_vec_t    : one full operand/result vector (N lanes of W bits)
//   sched_state_e : scheduler state (INIT = array reset sequencing, RUN)
//   trk_entry_t   : one in-flight tracker slot {valid, requester tag}
// -----------------------------------------------------------------------------
package array_mult_pkg;

    localparam int N            = 15;
    localparam int W            = 36;
    localparam int MULT_LAT_DEF = 4;

    // Tag field sized for the largest supported requester count (8).
    localparam int TRK_TAG_W    = 3;

    typedef logic [N-1:0][W-1:0] lane_vec_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic                 valid;
        logic [TRK_TAG_W-1:0] tag;
    } trk_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter owning the rotating priority pointer.
//   clk          : clock
//   rst          : asynchronous active-low reset (pointer returns to 0)
//   i_req        : request vector
//   i_adv        : a grant was taken this cycle; pointer moves past the winner
//   o_grant      : one-hot grant (or zero), combinational from i_req/pointer
//   o_grant_idx  : binary index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int TAG_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_adv,
    output logic [NREQ-1:0]  o_grant,
    output logic [TAG_W-1:0] o_grant_idx
);

    logic [TAG_W-1:0] r_ptr;
    logic             w_found;
    logic [TAG_W-1:0] w_cand;

    // Scan NREQ candidates starting at the pointer; first requester wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = TAG_W'((int'(r_ptr) + k) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_grant[w_cand]  = 1'b1;
                o_grant_idx      = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (int'(o_grant_idx) == NREQ - 1) ? '0 : o_grant_idx + TAG_W'(1);
        end
    end

endmodule

// File: rtl/array_mult_sched.sv
// -----------------------------------------------------------------------------
// array_mult_sched
// Shares one N-lane array multiplier between NREQ requesters. After reset the
// array's own reset is held for RST_CYC cycles (INIT), then requests are
// granted round-robin, one per cycle, and each result is routed back to its
// issuer after MULT_LAT enabled cycles.
//   clk, rst     : clock, asynchronous active-low reset
//   req_valid    : per-requester operation pending
//   req_ready    : per-requester grant (one-hot or zero)
//   req_a/req_b  : per-requester operand vectors
//   resp_valid   : per-requester result strobe (one-hot or zero)
//   resp_result  : result vector, shared by all requesters
//   mult_en      : array enable
//   mult_rst     : array synchronous reset, active-high
//   mult_a/b     : array operands
//   mult_result  : array result
//   busy         : at least one operation in flight
// -----------------------------------------------------------------------------
module array_mult_sched
    import array_mult_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int RST_CYC  = 4,
    parameter int TAG_W    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  lane_vec_t [NREQ-1:0]  req_a,
    input  lane_vec_t [NREQ-1:0]  req_b,
    output logic [NREQ-1:0]       resp_valid,
    output lane_vec_t             resp_result,
    output logic                  mult_en,
    output logic                  mult_rst,
    output lane_vec_t             mult_a,
    output lane_vec_t             mult_b,
    input  lane_vec_t             mult_result,
    output logic                  busy
);

    localparam int CNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    sched_state_e       r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mult_rst;
    trk_entry_t         r_trk [MULT_LAT];

    logic [NREQ-1:0]     w_req;
    logic [NREQ-1:0]     w_grant;
    logic [TAG_W-1:0]    w_grant_idx;
    logic                w_issue;
    logic [MULT_LAT-1:0] w_trk_v;
    trk_entry_t          w_last;

    // ---------------- array reset sequencing ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= INIT;
            r_cnt      <= '0;
            r_mult_rst <= 1'b1;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                        r_state    <= RUN;
                        r_mult_rst <= 1'b0;
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    assign mult_rst = r_mult_rst;

    // ---------------- arbitration and issue ----------------
    // Requests are masked during INIT so nothing reaches the array in reset.
    assign w_req = req_valid & {NREQ{r_state == RUN}};

    rr_arbiter #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (w_req),
        .i_adv       (w_issue),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign req_ready = w_grant;
    assign w_issue   = |w_grant;

    always_comb begin
        mult_a = '0;
        mult_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                mult_a = req_a[i];
                mult_b = req_b[i];
            end
        end
    end

    // ---------------- in-flight tracker ----------------
    // Advances in lockstep with the array (same enable) so tags stay aligned
    // with the data even when the array stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                r_trk[i] <= '0;
            end
        end else if (mult_en) begin
            r_trk[0].valid <= w_issue;
            r_trk[0].tag   <= TRK_TAG_W'(w_grant_idx);
            for (int i = 1; i < MULT_LAT; i++) begin
                r_trk[i] <= r_trk[i-1];
            end
        end
    end

    for (genvar gi = 0; gi < MULT_LAT; gi++) begin : g_trk_v
        assign w_trk_v[gi] = r_trk[gi].valid;
    end

    assign busy    = |w_trk_v;
    assign mult_en = w_issue | busy;

    // ---------------- response routing ----------------
    assign w_last      = r_trk[MULT_LAT-1];
    assign resp_result = mult_result;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
        assign resp_valid[gi] = w_last.valid & mult_en & (w_last.tag == TRK_TAG_W'(gi));
    end

endmodule

// File: tb/tb_array_mult_sched.sv
`timescale 1ns/1ps
module tb_array_mult_sched;
    import array_mult_pkg::*;

    localparam int NREQ     = 3;
    localparam int MULT_LAT = 4;
    localparam int RST_CYC  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    lane_vec_t [NREQ-1:0] req_a;
    lane_vec_t [NREQ-1:0] req_b;
    logic [NREQ-1:0]      resp_valid;
    lane_vec_t            resp_result;
    logic                 mult_en;
    logic                 mult_rst;
    lane_vec_t            mult_a;
    lane_vec_t            mult_b;
    lane_vec_t            mult_result;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rel_cnt = 0;   // clock edges seen since rst was released
    int mrst_cnt = 0;  // cycles with rst released and mult_rst high

    array_mult_sched #(
        .NREQ     (NREQ),
        .MULT_LAT (MULT_LAT),
        .RST_CYC  (RST_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .mult_en     (mult_en),
        .mult_rst    (mult_rst),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_result (mult_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) rel_cnt <= 0;
        else      rel_cnt <= rel_cnt + 1;
    end

    task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic lane_vec_t prod(input lane_vec_t a, input lane_vec_t b);
        lane_vec_t        r;
        logic [2*W-1:0]   p;
        for (int l = 0; l < N; l++) begin
            p    = {{W{1'b0}}, a[l]} * {{W{1'b0}}, b[l]};
            r[l] = p[W-1:0];
        end
        return r;
    endfunction

    function automatic lane_vec_t fill(input logic [W-1:0] v);
        lane_vec_t r;
        for (int l = 0; l < N; l++) r[l] = v;
        return r;
    endfunction

    function automatic lane_vec_t ramp(input int base);
        lane_vec_t r;
        for (int l = 0; l < N; l++) r[l] = W'(base + l);
        return r;
    endfunction

    // Behavioural stand-in for the array: MULT_LAT-deep product pipeline.
    lane_vec_t am [MULT_LAT];
    always @(posedge clk) begin
        if (mult_rst) begin
            for (int i = 0; i < MULT_LAT; i++) am[i] <= '0;
        end else if (mult_en) begin
            am[0] <= prod(mult_a, mult_b);
            for (int i = 1; i < MULT_LAT; i++) am[i] <= am[i-1];
        end
    end
    assign mult_result = am[MULT_LAT-1];

    // ---------------- scoreboard model ----------------
    typedef struct {
        int        tag;
        int        due;
        lane_vec_t res;
    } exp_t;

    exp_t      q [$];
    int        glog_tag [$];
    int        glog_cyc [$];
    int        rlog_tag [$];
    int        rlog_cyc [$];
    lane_vec_t rlog_res [$];

    int              ptr_m = 0;
    int              gidx;
    logic [NREQ-1:0] exp_g;
    logic [NREQ-1:0] exp_rv;
    logic            busy_m;
    logic            found;
    exp_t            e;

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            ptr_m    = 0;
            mrst_cnt = 0;
            chk("rst_req_ready",  req_ready,  '0);
            chk("rst_resp_valid", resp_valid, '0);
            chk("rst_mult_en",    mult_en,    1'b0);
            chk("rst_mult_rst",   mult_rst,   1'b1);
            chk("rst_busy",       busy,       1'b0);
            chk("rst_mult_a",     mult_a,     '0);
            chk("rst_mult_b",     mult_b,     '0);
        end else begin
            if (mult_rst) mrst_cnt++;
            chk("mult_rst", mult_rst, (rel_cnt < RST_CYC));

            // expected grant: first pending requester at or after the pointer
            exp_g = '0;
            gidx  = 0;
            found = 1'b0;
            if (rel_cnt >= RST_CYC) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req_valid[(ptr_m + k) % NREQ]) begin
                        found = 1'b1;
                        gidx  = (ptr_m + k) % NREQ;
                        exp_g[gidx] = 1'b1;
                    end
                end
            end

            busy_m = (q.size() > 0);
            exp_rv = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_rv[q[0].tag] = 1'b1;
                chk("resp_result", resp_result, q[0].res);
                chk("resp_passthru", resp_result, mult_result);
                void'(q.pop_front());
            end
            chk("resp_valid", resp_valid, exp_rv);
            chk("req_ready", req_ready, exp_g);

            if (found) begin
                chk("mult_a", mult_a, req_a[gidx]);
                chk("mult_b", mult_b, req_b[gidx]);
                e.tag = gidx;
                e.due = cyc + MULT_LAT;
                e.res = prod(req_a[gidx], req_b[gidx]);
                q.push_back(e);
                ptr_m = (gidx + 1) % NREQ;
            end else begin
                chk("mult_a_idle", mult_a, '0);
                chk("mult_b_idle", mult_b, '0);
            end
            chk("busy", busy, busy_m);
            chk("mult_en", mult_en, busy_m | found);

            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i]) begin glog_tag.push_back(i); glog_cyc.push_back(cyc); end
            end
            if (resp_valid != '0) begin
                for (int i = 0; i < NREQ; i++)
                    if (resp_valid[i]) begin
                        rlog_tag.push_back(i);
                        rlog_cyc.push_back(cyc);
                        rlog_res.push_back(resp_result);
                    end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int idx);
        logic g;
        g = 1'b0;
        req_valid[idx] = 1'b1;
        for (int t = 0; t < 20 && !g; t++) begin
            @(negedge clk);
            g = req_ready[idx];
            @(posedge clk);
            #1;
        end
        req_valid[idx] = 1'b0;
        chk("issue_granted", g, 1'b1);
        $display("[TB] issue req%0d granted=%0d cycle %0d", idx, g, cyc - 1);
    endtask

    int        rel_cyc, gb, rb;
    lane_vec_t v;

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        step(3);

        // reset sequence; requester 2 raises its request while still in INIT
        req_a[2] = ramp(100);
        req_b[2] = fill(3);
        rst      = 1'b1;
        rel_cyc  = cyc;
        issue(2);
        chk("init_len", mrst_cnt, RST_CYC);
        chk("init_first_tag", glog_tag[0], 2);
        chk("init_first_cyc", glog_cyc[0], rel_cyc + 4);
        step(6);

        // round-robin with all three requesters pending for 6 cycles
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = ramp(i * 1000 + 1);
            req_b[i] = ramp(i * 7 + 2);
        end
        gb = glog_tag.size();
        rb = rlog_tag.size();
        req_valid = '1;
        step(6);
        req_valid = '0;
        step(8);
        chk("rr_grant_cnt", glog_tag.size(), gb + 6);
        chk("rr_resp_cnt",  rlog_tag.size(), rb + 6);
        for (int k = 0; k < 6; k++) begin
            chk("rr_grant_order", glog_tag[gb + k], k % 3);
            chk("rr_resp_order",  rlog_tag[rb + k], k % 3);
            chk("rr_resp_cyc",    rlog_cyc[rb + k], glog_cyc[gb] + 4 + k);
        end
        $display("[TB] round-robin burst done, grants from cycle %0d", glog_cyc[gb]);

        // single op: requester 1, A=3 B=5 on every lane
        req_a[1] = fill(3);
        req_b[1] = fill(5);
        gb = glog_tag.size();
        rb = rlog_tag.size();
        issue(1);
        step(6);
        chk("single_cnt", rlog_tag.size(), rb + 1);
        chk("single_tag", rlog_tag[rb], 1);
        v = rlog_res[rb];
        chk("single_lane0",  v[0],  15);
        chk("single_lane14", v[14], 15);
        chk("single_lat", rlog_cyc[rb] - glog_cyc[gb], 4);
        $display("[TB] single op resp cycle %0d", rlog_cyc[rb]);

        // idle gap between two ops
        req_a[2] = ramp(50);
        req_b[2] = fill(9);
        req_a[0] = fill(11);
        req_b[0] = ramp(20);
        gb = glog_tag.size();
        rb = rlog_tag.size();
        issue(2);
        step(10);
        issue(0);
        step(8);
        chk("gap_cnt",  rlog_tag.size(), rb + 2);
        chk("gap_tagX", rlog_tag[rb], 2);
        chk("gap_tagY", rlog_tag[rb + 1], 0);
        chk("gap_latX", rlog_cyc[rb] - glog_cyc[gb], 4);
        chk("gap_latY", rlog_cyc[rb + 1] - glog_cyc[gb + 1], 4);
        $display("[TB] idle gap ops done");

        // mid-flight reset: three ops in flight, then reset
        rb = rlog_tag.size();
        req_valid = '1;
        step(3);
        req_valid = '0;
        rst = 1'b0;
        step(3);
        req_a[0] = fill(6);
        req_b[0] = ramp(1);
        rst      = 1'b1;
        rel_cyc  = cyc;
        gb = glog_tag.size();
        issue(0);
        step(6);
        chk("midrst_init_len", mrst_cnt, RST_CYC);
        chk("midrst_resp_cnt", rlog_tag.size(), rb + 1);
        chk("midrst_tag", rlog_tag[rb], 0);
        chk("midrst_grant_cyc", glog_cyc[gb], rel_cyc + 4);
        $display("[TB] mid-flight reset recovered, new resp cycle %0d", rlog_cyc[rb]);

        // corner operands: all-ones x 1 and zero x pattern, interleaved lanes
        for (int l = 0; l < N; l++) begin
            req_a[0][l] = (l % 2 == 0) ? {W{1'b1}} : '0;
            req_b[0][l] = (l % 2 == 0) ? W'(1) : W'(36'hABCDE1234);
        end
        rb = rlog_tag.size();
        issue(0);
        step(6);
        chk("corner_cnt", rlog_tag.size(), rb + 1);
        v = rlog_res[rb];
        chk("corner_lane0",  v[0],  {W{1'b1}});
        chk("corner_lane1",  v[1],  '0);
        chk("corner_lane14", v[14], {W{1'b1}});
        $display("[TB] corner operands done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
